riscv_lsu: RTL and testbench

Load/store unit for the memory stage. It takes the effective address (ALU result) and store data from execute, runs a valid/ready transaction on the data-memory port, and aligns and sign-extends load data. The load result drives the `data` input of riscv_wb_mux, which selects it when wb_sel = WB_MEM. The unit stalls the pipeline while a transaction is outstanding.

---
 rtl/riscv_constants.sv | 37 +++
 rtl/riscv_load_align.sv | 32 +++
 rtl/riscv_lsu.sv | 190 +++++++++++++++++++
 tb/tb_riscv_lsu.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_constants.sv
// Shared pipeline encodings: writeback select and memory-operation codes.
// Latency: n/a (types only). Backpressure: n/a.
// Helpers classify memory ops by direction and access width.
package riscv_constants;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_half(input mem_op_t op);
        return (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    endfunction

    function automatic logic is_word(input mem_op_t op);
        return (op == MEM_LW) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
// Latency: combinational. Backpressure: none.
// Non-load ops yield zero.
module riscv_load_align
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  mem_op_t                mem_op,
    input  logic [1:0]             offset,
    input  logic [WORD_LENGTH-1:0] rdata,
    output logic [WORD_LENGTH-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        result   = '0;
        case (mem_op)
            MEM_LB:  result = {{(WORD_LENGTH-8){byte_sel[7]}}, byte_sel};
            MEM_LBU: result = {{(WORD_LENGTH-8){1'b0}}, byte_sel};
            MEM_LH:  result = {{(WORD_LENGTH-16){half_sel[15]}}, half_sel};
            MEM_LHU: result = {{(WORD_LENGTH-16){1'b0}}, half_sel};
            MEM_LW:  result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit; optional misaligned trap under RISCV_LSU_MISALIGN_TRAP_EN.
// Latency: >= 4 cycles start-to-done (IDLE, REQ, WAIT, DONE); trapped accesses 2 cycles.
// Backpressure: holds REQ fields until dmem_req_ready, waits in WAIT for dmem_rsp_valid; stall high meanwhile.
module riscv_lsu
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  mem_op_t                mem_op,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [WORD_LENGTH-1:0] wdata,
    output logic                   stall,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] data,
    output logic                   dmem_req_valid,
    input  logic                   dmem_req_ready,
    output logic                   dmem_we,
    output logic [ADDR_WIDTH-1:0]  dmem_addr,
    output logic [WORD_LENGTH-1:0] dmem_wdata,
    output logic [3:0]             dmem_wstrb,
    input  logic                   dmem_rsp_valid,
    input  logic [WORD_LENGTH-1:0] dmem_rdata,
    output logic                   misaligned
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    mem_op_t                op_q;
    logic [1:0]             off_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WORD_LENGTH-1:0] wdata_q;
    logic [3:0]             wstrb_q;
    logic [WORD_LENGTH-1:0] data_q;
    logic [WORD_LENGTH-1:0] load_word;

    logic                   start;
    logic                   trap;
    logic [1:0]             off_eff;
    logic [WORD_LENGTH-1:0] lane_wdata;
    logic [3:0]             lane_wstrb;

    assign start = ex_valid && (mem_op != MEM_NONE);

    // Width-aligned offset: half ignores bit 0, word ignores both bits.
    always_comb begin
        off_eff = addr[1:0];
        if (is_half(mem_op)) begin
            off_eff = {addr[1], 1'b0};
        end else if (is_word(mem_op)) begin
            off_eff = 2'b00;
        end
    end

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign trap = (is_half(mem_op) && addr[0]) || (is_word(mem_op) && (addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            mis_q <= trap;
        end
    end

    assign misaligned = (state == S_DONE) && mis_q;
`else
    assign trap       = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        lane_wdata = '0;
        lane_wstrb = 4'b0000;
        case (mem_op)
            MEM_SB: begin
                lane_wdata = {4{wdata[7:0]}};
                lane_wstrb = 4'b0001 << off_eff;
            end
            MEM_SH: begin
                lane_wdata = {2{wdata[15:0]}};
                lane_wstrb = 4'b0011 << {off_eff[1], 1'b0};
            end
            MEM_SW: begin
                lane_wdata = wdata;
                lane_wstrb = 4'b1111;
            end
            default: begin
                lane_wdata = '0;
                lane_wstrb = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        stall          = 1'b0;
        done           = 1'b0;
        dmem_req_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    state_nxt = trap ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall          = 1'b1;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (dmem_rsp_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request fields are captured at start so execute may move on.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= MEM_NONE;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
        end else if ((state == S_IDLE) && start) begin
            op_q    <= mem_op;
            off_q   <= off_eff;
            we_q    <= is_store(mem_op);
            addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= lane_wdata;
            wstrb_q <= lane_wstrb;
        end
    end

    riscv_load_align #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_load_align (
        .mem_op(op_q),
        .offset(off_q),
        .rdata (dmem_rdata),
        .result(load_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if ((state == S_WAIT) && dmem_rsp_valid && !we_q) begin
            data_q <= load_word;
        end
    end

    assign data       = data_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed vectors, corner sequences, randomized ops vs. a reference model.
module tb_riscv_lsu;
    import riscv_constants::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    mem_op_t     mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] data;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        misaligned;

    always #5 clk = ~clk;

    riscv_lsu #(.WORD_LENGTH(32), .ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .mem_op        (mem_op),
        .addr          (addr),
        .wdata         (wdata),
        .stall         (stall),
        .done          (done),
        .data          (data),
        .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata    (dmem_rdata),
        .misaligned    (misaligned)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mdata;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        we;
        logic        mis;
        logic        stall_ok;
        logic        stable_ok;
        logic        timeout;
        int          cycles;
        int          req_cycles;
        int          rsp_cycle;
        int          done_cycle;
    } res_t;

    typedef struct {
        mem_op_t     op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        logic        exp_we;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference model from the architectural rules of RV32 loads/stores.
    task automatic model(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [31:0] prev,
                         output logic [31:0] nd, output logic [31:0] ea, output logic [31:0] ew,
                         output logic [3:0] es, output logic ewe, output logic emis);
        int unsigned off;
        int unsigned b;
        int unsigned h;
        logic half_op;
        logic word_op;
        off     = a % 4;
        half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word_op = (op == MEM_LW) || (op == MEM_SW);
        ea      = a - off;
        ewe     = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
        ew      = 32'h0;
        es      = 4'h0;
        nd      = prev;
        emis    = 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        if ((half_op && (off % 2 == 1)) || (word_op && off != 0)) begin
            emis = 1'b1;
            return;
        end
`else
        if (half_op) off = off - (off % 2);
        if (word_op) off = 0;
`endif
        b = (rd >> (8 * off)) % 256;
        h = (rd >> (8 * off)) % 65536;
        case (op)
            MEM_LB:  nd = (b >= 128) ? b + 32'hFFFFFF00 : b;
            MEM_LBU: nd = b;
            MEM_LH:  nd = (h >= 32768) ? h + 32'hFFFF0000 : h;
            MEM_LHU: nd = h;
            MEM_LW:  nd = rd;
            MEM_SB: begin
                ew = (wd % 256) * 32'h01010101;
                es = 4'(1 << off);
            end
            MEM_SH: begin
                ew = (wd % 65536) * 32'h00010001;
                es = 4'(3 << off);
            end
            MEM_SW: begin
                ew = wd;
                es = 4'hF;
            end
            default: nd = prev;
        endcase
    endtask

    // Issues one op from IDLE and plays a memory with the given ready/response delays.
    task automatic run_op(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int rdy_lat, input int rsp_lat,
                          output res_t r);
        int cyc;
        int nreq;
        int nwait;
        bit accepted;
        bit fin;
        r = '0;
        @(posedge clk); #1;
        ex_valid       = 1'b1;
        mem_op         = op;
        addr           = a;
        wdata          = wd;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        #1;
        r.stall_ok  = stall;
        r.stable_ok = 1'b1;
        cyc = 1; nreq = 0; nwait = 0; accepted = 0; fin = 0;
        while (!fin && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            ex_valid       = 1'b0;
            mem_op         = MEM_NONE;
            addr           = $urandom;
            wdata          = $urandom;
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            dmem_rdata     = $urandom;
            if (done) begin
                fin          = 1;
                r.done_cycle = cyc;
                r.data       = data;
                r.mis        = misaligned;
                if (stall) r.stall_ok = 1'b0;
            end else begin
                if (!stall) r.stall_ok = 1'b0;
                if (dmem_req_valid) begin
                    if (nreq == 0) begin
                        r.addr  = dmem_addr;
                        r.wdata = dmem_wdata;
                        r.strb  = dmem_wstrb;
                        r.we    = dmem_we;
                    end else if (r.addr !== dmem_addr || r.wdata !== dmem_wdata ||
                                 r.strb !== dmem_wstrb || r.we !== dmem_we) begin
                        r.stable_ok = 1'b0;
                    end
                    if (nreq >= rdy_lat) begin
                        dmem_req_ready = 1'b1;
                        accepted       = 1;
                    end
                    nreq++;
                end else if (accepted) begin
                    if (nwait >= rsp_lat) begin
                        dmem_rsp_valid = 1'b1;
                        dmem_rdata     = rd;
                        r.rsp_cycle    = cyc;
                    end
                    nwait++;
                end
            end
        end
        r.timeout    = !fin;
        r.cycles     = cyc;
        r.req_cycles = nreq;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        r;
        logic [31:0] nd, ea, ew;
        logic [3:0]  es;
        logic        ewe, emis;
        mem_op_t     rop;
        logic [31:0] ra, rw, rr;
        int          rl, pl;

        vt[0] = '{MEM_LW,  32'h100, 32'h0,      32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 32'h0,      4'h0, 1'b0};
        vt[1] = '{MEM_LB,  32'h103, 32'h0,      32'h80FF0000, 32'hFFFFFF80, 32'h100, 32'h0,      4'h0, 1'b0};
        vt[2] = '{MEM_LBU, 32'h103, 32'h0,      32'h80FF0000, 32'h00000080, 32'h100, 32'h0,      4'h0, 1'b0};
        vt[3] = '{MEM_SH,  32'h202, 32'h1234ABCD, 32'h0,      32'h00000080, 32'h200, 32'hABCDABCD, 4'hC, 1'b1};
        vt[4] = '{MEM_LH,  32'h006, 32'h0,      32'h80017FFF, 32'hFFFF8001, 32'h004, 32'h0,      4'h0, 1'b0};
        vt[5] = '{MEM_LHU, 32'h008, 32'h0,      32'h8001F00D, 32'h0000F00D, 32'h008, 32'h0,      4'h0, 1'b0};
        vt[6] = '{MEM_SB,  32'h301, 32'h000000A5, 32'h0,      32'h0000F00D, 32'h300, 32'hA5A5A5A5, 4'h2, 1'b1};
        vt[7] = '{MEM_SW,  32'h400, 32'hCAFEF00D, 32'h0,      32'h0000F00D, 32'h400, 32'hCAFEF00D, 4'hF, 1'b1};
        vt[8] = '{MEM_LB,  32'h001, 32'h0,      32'h00007F00, 32'h0000007F, 32'h000, 32'h0,      4'h0, 1'b0};

        rst = 1'b1; ex_valid = 1'b0; mem_op = MEM_NONE; addr = 32'h0; wdata = 32'h0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_req_valid", 32'(dmem_req_valid), 32'h0);
        chk("rst_we", 32'(dmem_we), 32'h0);
        chk("rst_mis", 32'(misaligned), 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'h0);
        rst = 1'b0;

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].wd, vt[i].rd, 0, 0, r);
            chk($sformatf("vec%0d_timeout", i), 32'(r.timeout), 32'h0);
            chk($sformatf("vec%0d_cycles", i), 32'(r.cycles), 32'd4);
            chk($sformatf("vec%0d_stall", i), 32'(r.stall_ok), 32'h1);
            chk($sformatf("vec%0d_data", i), r.data, vt[i].exp_data);
            chk($sformatf("vec%0d_addr", i), r.addr, vt[i].exp_addr);
            chk($sformatf("vec%0d_we", i), 32'(r.we), 32'(vt[i].exp_we));
            chk($sformatf("vec%0d_wstrb", i), 32'(r.strb), 32'(vt[i].exp_strb));
            if (vt[i].exp_we) chk($sformatf("vec%0d_wdata", i), r.wdata, vt[i].exp_wdata);
        end
        mdata = 32'h0000007F;

        // Slow bus: ready after 3 cycles, response 2 cycles after acceptance.
        model(MEM_LH, 32'h10A, 32'h0, 32'h80017FFF, mdata, nd, ea, ew, es, ewe, emis);
        run_op(MEM_LH, 32'h10A, 32'h0, 32'h80017FFF, 3, 2, r);
        chk("slow_timeout", 32'(r.timeout), 32'h0);
        chk("slow_stable", 32'(r.stable_ok), 32'h1);
        chk("slow_req_cycles", 32'(r.req_cycles), 32'd4);
        chk("slow_done_after_rsp", 32'(r.done_cycle), 32'(r.rsp_cycle + 1));
        chk("slow_cycles", 32'(r.cycles), 32'd9);
        chk("slow_addr", r.addr, ea);
        chk("slow_data", r.data, nd);
        mdata = nd;

        // Spurious response while idle, then idle ops that must not start.
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'h55555555;
        ex_valid = 1'b1; mem_op = MEM_NONE;
        #1;
        chk("idle_none_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        ex_valid = 1'b0; mem_op = MEM_LW;
        #1;
        chk("idle_rsp_done", 32'(done), 32'h0);
        chk("idle_rsp_data", data, mdata);
        chk("idle_novalid_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        chk("idle_no_req", 32'(dmem_req_valid), 32'h0);
        chk("idle_no_done", 32'(done), 32'h0);
        mem_op = MEM_NONE;

        // Reset during WAIT, then a late response.
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_op = MEM_LW; addr = 32'h500;
        @(posedge clk); #1;
        ex_valid = 1'b0; mem_op = MEM_NONE;
        chk("rstw_req", 32'(dmem_req_valid), 32'h1);
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        chk("rstw_wait_stall", 32'(stall), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'h12345678;
        #1;
        chk("rstw_stall", 32'(stall), 32'h0);
        chk("rstw_ctrl", {27'h0, done, dmem_req_valid, dmem_we, misaligned, 1'b0}, 32'h0);
        chk("rstw_addr", dmem_addr, 32'h0);
        chk("rstw_lanes", dmem_wdata | 32'(dmem_wstrb), 32'h0);
        chk("rstw_data", data, 32'h0);
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        chk("rstw_late_done", 32'(done), 32'h0);
        chk("rstw_late_data", data, 32'h0);
        mdata = 32'h0;

        // Misaligned word access.
        run_op(MEM_LW, 32'h101, 32'h0, 32'hA1B2C3D4, 0, 0, r);
        chk("mis_timeout", 32'(r.timeout), 32'h0);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        chk("mis_flag", 32'(r.mis), 32'h1);
        chk("mis_cycles", 32'(r.cycles), 32'd2);
        chk("mis_no_req", 32'(r.req_cycles), 32'd0);
        chk("mis_data", r.data, mdata);
`else
        chk("mis_flag", 32'(r.mis), 32'h0);
        chk("mis_cycles", 32'(r.cycles), 32'd4);
        chk("mis_addr", r.addr, 32'h100);
        chk("mis_data", r.data, 32'hA1B2C3D4);
        mdata = 32'hA1B2C3D4;
`endif

        for (int n = 0; n < 300; n++) begin
            rop = mem_op_t'($urandom_range(1, 8));
            ra  = $urandom;
            rw  = $urandom;
            rr  = $urandom;
            rl  = $urandom_range(0, 3);
            pl  = $urandom_range(0, 3);
            model(rop, ra, rw, rr, mdata, nd, ea, ew, es, ewe, emis);
            run_op(rop, ra, rw, rr, rl, pl, r);
            chk($sformatf("rnd%0d_timeout", n), 32'(r.timeout), 32'h0);
            chk($sformatf("rnd%0d_stall", n), 32'(r.stall_ok), 32'h1);
            chk($sformatf("rnd%0d_mis", n), 32'(r.mis), 32'(emis));
            chk($sformatf("rnd%0d_data", n), r.data, nd);
            if (emis) begin
                chk($sformatf("rnd%0d_noreq", n), 32'(r.req_cycles), 32'd0);
            end else begin
                chk($sformatf("rnd%0d_addr", n), r.addr, ea);
                chk($sformatf("rnd%0d_we", n), 32'(r.we), 32'(ewe));
                chk($sformatf("rnd%0d_wstrb", n), 32'(r.strb), 32'(es));
                chk($sformatf("rnd%0d_stable", n), 32'(r.stable_ok), 32'h1);
                chk($sformatf("rnd%0d_done_lat", n), 32'(r.done_cycle), 32'(r.rsp_cycle + 1));
                if (ewe) chk($sformatf("rnd%0d_wdata", n), r.wdata, ew);
            end
            mdata = nd;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
